// File: rtl/fp32_add_pipe.sv
// Three-stage pipelined IEEE-754 single-precision adder, denormals flushed to zero.
// Build option: define FP_ADD_RNE_EN for round-to-nearest-even, otherwise results are truncated.
module fp32_add_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] NumA,
  input  logic [31:0] NumB,
  output logic        out_valid,
  output logic [31:0] NumOut
);
  localparam int unsigned EXT_W = 27;
  localparam int unsigned SUM_W = 28;
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;
`ifdef FP_ADD_RNE_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  logic             a_sign, b_sign;
  logic [7:0]       a_exp, b_exp;
  logic [22:0]      a_frac, b_frac;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic             a_is_l;
  logic             l_sign;
  logic [7:0]       l_exp, s_exp, align_d;
  logic [23:0]      l_mant, s_mant;
  logic [EXT_W-1:0] s_field, s_shift, s_ext;
  logic             s_sticky;
  logic             spec_hit;
  logic [31:0]      spec_val;

  assign a_sign = NumA[31];
  assign b_sign = NumB[31];
  assign a_exp  = NumA[30:23];
  assign b_exp  = NumB[30:23];
  assign a_frac = NumA[22:0];
  assign b_frac = NumB[22:0];
  assign a_zero = (a_exp == 8'd0);
  assign b_zero = (b_exp == 8'd0);
  assign a_inf  = (a_exp == 8'hFF) && (a_frac == 23'd0);
  assign b_inf  = (b_exp == 8'hFF) && (b_frac == 23'd0);
  assign a_nan  = (a_exp == 8'hFF) && (a_frac != 23'd0);
  assign b_nan  = (b_exp == 8'hFF) && (b_frac != 23'd0);
  // Denormals compare as zero so the flushed operand always lands on the small side.
  assign a_is_l = (a_zero ? 31'd0 : NumA[30:0]) >= (b_zero ? 31'd0 : NumB[30:0]);

  // Swap so L >= S, then align S with guard/round/sticky.
  always_comb begin
    l_sign   = a_is_l ? a_sign : b_sign;
    l_exp    = a_is_l ? a_exp : b_exp;
    s_exp    = a_is_l ? b_exp : a_exp;
    l_mant   = a_is_l ? (a_zero ? 24'd0 : {1'b1, a_frac}) : (b_zero ? 24'd0 : {1'b1, b_frac});
    s_mant   = a_is_l ? (b_zero ? 24'd0 : {1'b1, b_frac}) : (a_zero ? 24'd0 : {1'b1, a_frac});
    align_d  = l_exp - s_exp;
    s_field  = {s_mant, 3'b000};
    s_shift  = '0;
    s_sticky = 1'b0;
    if (align_d >= 8'd27) begin
      s_sticky = |s_field;
    end else begin
      s_shift  = s_field >> align_d;
      s_sticky = |(s_field & ~({EXT_W{1'b1}} << align_d));
    end
    s_ext = {s_shift[EXT_W-1:1], s_shift[0] | s_sticky};
  end

  // Special-operand results, resolved in priority order.
  always_comb begin
    spec_hit = 1'b1;
    spec_val = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign))) begin
      spec_val = QNAN;
    end else if (a_inf) begin
      spec_val = {a_sign, 8'hFF, 23'd0};
    end else if (b_inf) begin
      spec_val = {b_sign, 8'hFF, 23'd0};
    end else if (a_zero && b_zero) begin
      spec_val = {a_sign & b_sign, 31'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic             s1_valid, s1_sub, s1_sign, s1_spec;
  logic [7:0]       s1_exp;
  logic [EXT_W-1:0] s1_lm, s1_sm;
  logic [31:0]      s1_spec_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_sub      <= 1'b0;
      s1_sign     <= 1'b0;
      s1_spec     <= 1'b0;
      s1_exp      <= '0;
      s1_lm       <= '0;
      s1_sm       <= '0;
      s1_spec_val <= '0;
    end else begin
      s1_valid    <= in_valid;
      s1_sub      <= a_sign ^ b_sign;
      s1_sign     <= l_sign;
      s1_spec     <= spec_hit;
      s1_exp      <= l_exp;
      s1_lm       <= {l_mant, 3'b000};
      s1_sm       <= s_ext;
      s1_spec_val <= spec_val;
    end
  end

  logic             s2_valid, s2_sign, s2_spec;
  logic [7:0]       s2_exp;
  logic [SUM_W-1:0] s2_sum;
  logic [31:0]      s2_spec_val;

  // Magnitude add/subtract; L >= S so the difference never goes negative.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_spec     <= 1'b0;
      s2_exp      <= '0;
      s2_sum      <= '0;
      s2_spec_val <= '0;
    end else begin
      s2_valid    <= s1_valid;
      s2_sign     <= s1_sign;
      s2_spec     <= s1_spec;
      s2_exp      <= s1_exp;
      s2_sum      <= s1_sub ? ({1'b0, s1_lm} - {1'b0, s1_sm}) : ({1'b0, s1_lm} + {1'b0, s1_sm});
      s2_spec_val <= s1_spec_val;
    end
  end

  logic [4:0]        lz;
  logic              lz_found;
  logic [EXT_W-1:0]  n_mant;
  logic signed [9:0] exp10, n_exp, r_exp;
  logic              round_inc;
  logic [24:0]       r_mant;
  logic [22:0]       r_frac;
  logic [31:0]       result_c;

  // Normalize, round and pack.
  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!lz_found && s2_sum[i]) begin
        lz       = 5'(26 - i);
        lz_found = 1'b1;
      end
    end
    exp10 = signed'({2'b00, s2_exp});
    if (s2_sum[SUM_W-1]) begin
      n_mant = {s2_sum[27:2], s2_sum[1] | s2_sum[0]};
      n_exp  = exp10 + 10'sd1;
    end else begin
      n_mant = s2_sum[EXT_W-1:0] << lz;
      n_exp  = exp10 - signed'({5'b00000, lz});
    end
    round_inc = RNE_EN & n_mant[2] & (n_mant[1] | n_mant[0] | n_mant[3]);
    r_mant    = {1'b0, n_mant[26:3]} + 25'(round_inc);
    r_exp     = r_mant[24] ? (n_exp + 10'sd1) : n_exp;
    r_frac    = r_mant[24] ? r_mant[23:1] : r_mant[22:0];

    if (s2_spec) begin
      result_c = s2_spec_val;
    end else if (s2_sum == '0) begin
      result_c = 32'h0000_0000;
    end else if (r_exp >= 10'sd255) begin
      result_c = {s2_sign, 8'hFF, 23'd0};
    end else if (r_exp <= 10'sd0) begin
      result_c = {s2_sign, 31'd0};
    end else begin
      result_c = {s2_sign, r_exp[7:0], r_frac};
    end
  end

  // NumOut only changes on a valid result so it holds through bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      NumOut    <= '0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        NumOut <= result_c;
      end
    end
  end

endmodule

// File: tb/tb_fp32_add_pipe.sv
// Self-checking bench for fp32_add_pipe: directed vectors plus randomized streams
// checked against an exact-arithmetic reference model (FTZ, selected rounding mode).
module tb_fp32_add_pipe;
  localparam int unsigned MW = 288;
`ifdef FP_ADD_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] NumA = '0;
  logic [31:0] NumB = '0;
  logic        out_valid;
  logic [31:0] NumOut;

  int n_tests = 0;
  int n_fail  = 0;

  fp32_add_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .NumA(NumA), .NumB(NumB),
    .out_valid(out_valid), .NumOut(NumOut)
  );

  always #5 clk = ~clk;

  // Exact sum as a wide integer, rounded once to 24 significant bits.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic sa, sb, rs, a_nan, b_nan, a_inf, b_inf, rnd_up;
    int ea, eb, emin, p, e;
    logic [MW-1:0] va, vb, mag, rest, half, one;
    logic [24:0] kept;
    sa = a[31]; sb = b[31];
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    a_nan = (ea == 255) && (a[22:0] != 0);
    b_nan = (eb == 255) && (b[22:0] != 0);
    a_inf = (ea == 255) && (a[22:0] == 0);
    b_inf = (eb == 255) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf && sa != sb)) return 32'h7FC0_0000;
    if (a_inf) return {sa, 8'hFF, 23'd0};
    if (b_inf) return {sb, 8'hFF, 23'd0};
    if (ea == 0 && eb == 0) return {sa & sb, 31'd0};
    if (ea == 0) return b;
    if (eb == 0) return a;
    emin = (ea < eb) ? ea : eb;
    one  = MW'(1);
    va   = MW'({1'b1, a[22:0]}) << (ea - emin);
    vb   = MW'({1'b1, b[22:0]}) << (eb - emin);
    if (sa == sb) begin
      mag = va + vb; rs = sa;
    end else if (va >= vb) begin
      mag = va - vb; rs = sa;
    end else begin
      mag = vb - va; rs = sb;
    end
    if (mag == '0) return 32'h0000_0000;
    p = 0;
    for (int i = 0; i < int'(MW); i++) if (mag[i]) p = i;
    if (p > 23) begin
      kept   = 25'(mag >> (p - 23));
      rest   = mag & ((one << (p - 23)) - one);
      half   = one << (p - 24);
      rnd_up = (rest > half) || (rest == half && kept[0]);
      if (RNE && rnd_up) kept = kept + 25'd1;
    end else begin
      kept = 25'(mag << (23 - p));
    end
    e = emin + p - 23;
    if (kept[24]) begin kept = kept >> 1; e = e + 1; end
    if (e >= 255) return {rs, 8'hFF, 23'd0};
    if (e <= 0) return {rs, 31'd0};
    return {rs, 8'(e), kept[22:0]};
  endfunction

  function automatic logic [31:0] rand_mod(input int lo, input int hi);
    return {1'($urandom), 8'($urandom_range(hi, lo)), 23'($urandom)};
  endfunction

  function automatic logic [31:0] rand_near(input logic [31:0] a);
    return {1'($urandom), 8'(int'(a[30:23]) + int'($urandom_range(6, 0)) - 3), 23'($urandom)};
  endfunction

  task automatic rand_pair(output logic [31:0] a, output logic [31:0] b);
    case ($urandom_range(7, 0))
      0: begin a = $urandom; b = $urandom; end
      1: begin a = rand_mod(240, 254); b = rand_near(a); end
      2: begin a = rand_mod(100, 150); b = rand_mod(100, 150); end
      3, 4, 5: begin a = rand_mod(110, 140); b = rand_near(a); end
      6: begin a = rand_mod(100, 150); b = {~a[31], a[30:0]} ^ 32'($urandom_range(3, 0)); end
      default: begin a = rand_mod(1, 4); b = rand_near(a); end
    endcase
  endtask

  // Drive one pair, then wait (bounded) for out_valid; lat counts edges since issue.
  task automatic issue_collect(input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output int lat);
    @(negedge clk);
    NumA = a; NumB = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    res = NumOut;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; NumA = 32'h3F80_0000; NumB = 32'h3F80_0000;
    repeat (3) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_tests++;
    if (NumOut !== 32'h0) begin n_fail++; $display("FAIL reset_numout: got %h want 00000000", NumOut); end
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_drop[%0d]: out_valid %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_basic();
    logic [31:0] op_a [2] = '{32'h3F80_0000, 32'h3FC0_0000};
    logic [31:0] op_b [2] = '{32'h3F80_0000, 32'hBF80_0000};
    logic [31:0] want [2] = '{32'h4000_0000, 32'h3F00_0000};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 2; i++) begin
      issue_collect(op_a[i], op_b[i], res, lat);
      n_tests++;
      if (lat !== 3) begin n_fail++; $display("FAIL basic_latency[%0d]: got %0d want 3", i, lat); end
      n_tests++;
      if (res !== want[i]) begin n_fail++; $display("FAIL basic_sum[%0d]: %h+%h got %h want %h", i, op_a[i], op_b[i], res, want[i]); end
    end
  endtask

  task automatic test_cancel();
    logic [31:0] op_a [3] = '{32'h3F80_0000, 32'h3F80_0001, 32'h8080_0001};
    logic [31:0] op_b [3] = '{32'hBF80_0000, 32'hBF80_0000, 32'h0080_0000};
    logic [31:0] want [3] = '{32'h0000_0000, 32'h3400_0000, 32'h8000_0000};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue_collect(op_a[i], op_b[i], res, lat);
      n_tests++;
      if (lat !== 3) begin n_fail++; $display("FAIL cancel_latency[%0d]: got %0d want 3", i, lat); end
      n_tests++;
      if (res !== want[i]) begin n_fail++; $display("FAIL cancel_sum[%0d]: %h+%h got %h want %h", i, op_a[i], op_b[i], res, want[i]); end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] op_a [2] = '{32'h3F80_0000, 32'h3F80_0000};
    logic [31:0] op_b [2] = '{32'h3380_0000, 32'h33C0_0000};
    logic [31:0] want [2];
    logic [31:0] res;
    int lat;
    want[0] = 32'h3F80_0000;
    want[1] = RNE ? 32'h3F80_0001 : 32'h3F80_0000;
    for (int i = 0; i < 2; i++) begin
      issue_collect(op_a[i], op_b[i], res, lat);
      n_tests++;
      if (res !== want[i]) begin n_fail++; $display("FAIL round_sum[%0d]: %h+%h got %h want %h", i, op_a[i], op_b[i], res, want[i]); end
    end
  endtask

  task automatic test_specials();
    logic [31:0] op_a [7] = '{32'h7F7F_FFFF, 32'h7F80_0000, 32'h0040_0000, 32'h7F80_0001,
                              32'hFF80_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] op_b [7] = '{32'h7F7F_FFFF, 32'hFF80_0000, 32'h3F80_0000, 32'h3F80_0000,
                              32'h3F80_0000, 32'h8000_0000, 32'h0000_0000};
    logic [31:0] want [7] = '{32'h7F80_0000, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000,
                              32'hFF80_0000, 32'h8000_0000, 32'h0000_0000};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 7; i++) begin
      issue_collect(op_a[i], op_b[i], res, lat);
      n_tests++;
      if (res !== want[i]) begin n_fail++; $display("FAIL special_sum[%0d]: %h+%h got %h want %h", i, op_a[i], op_b[i], res, want[i]); end
    end
  endtask

  // 8 valid, 2 bubbles, 4 valid; output stream checked cycle by cycle.
  task automatic test_stream();
    localparam int N = 14;
    bit vpat [N] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
    logic [31:0] ra [N];
    logic [31:0] rb [N];
    logic [31:0] last;
    bit have_last;
    bit exp_v;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++) rand_pair(ra[k], rb[k]);
      have_last = 1'b0;
      last = '0;
      for (int t = 0; t < N + 4; t++) begin
        @(negedge clk);
        exp_v = (t >= 3 && t - 3 < N) ? vpat[t - 3] : 1'b0;
        n_tests++;
        if (out_valid !== exp_v) begin n_fail++; $display("FAIL stream_valid r%0d t%0d: got %b want %b", r, t, out_valid, exp_v); end
        if (exp_v) begin
          last = ref_add(ra[t - 3], rb[t - 3]);
          have_last = 1'b1;
          n_tests++;
          if (NumOut !== last) begin n_fail++; $display("FAIL stream_sum r%0d t%0d: %h+%h got %h want %h", r, t, ra[t - 3], rb[t - 3], NumOut, last); end
        end else if (have_last) begin
          n_tests++;
          if (NumOut !== last) begin n_fail++; $display("FAIL stream_hold r%0d t%0d: got %h want %h", r, t, NumOut, last); end
        end
        if (t < N) begin
          in_valid = vpat[t]; NumA = ra[t]; NumB = rb[t];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] res;
    int lat;
    @(negedge clk);
    NumA = 32'h3F80_0000; NumB = 32'h3F80_0000; in_valid = 1'b1;
    @(negedge clk);
    NumA = 32'h4000_0000; NumB = 32'h3F80_0000;
    @(negedge clk);
    rst = 1'b1; NumA = 32'h4040_0000; NumB = 32'h4040_0000;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    n_tests++;
    if (NumOut !== 32'h0) begin n_fail++; $display("FAIL midrst_numout: got %h want 00000000", NumOut); end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_flush[%0d]: out_valid %b want 0", i, out_valid); end
      @(negedge clk);
    end
    issue_collect(32'h4040_0000, 32'h3F80_0000, res, lat);
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL midrst_latency: got %0d want 3", lat); end
    n_tests++;
    if (res !== 32'h4080_0000) begin n_fail++; $display("FAIL midrst_sum: got %h want 40800000", res); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cancel();
    test_rounding();
    test_specials();
    test_stream();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
